sine_cfg_ctrl: RTL and testbench
================================

Name: sine_cfg_ctrl

Overview:
UART command controller that configures and sequences the PWM sine generator. It parses framed byte commands from the UART receiver and stages the phase increment and amplitude. Staged values are committed glitch-free on the generator's phase-wrap boundary, and run/stop is controlled directly. ACK, NAK and status bytes are returned through the UART transmitter handshake. The block sits between the UART RX/TX cores and the sine/PWM datapath inside the top-level design.

Parameters:
TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between bytes of one frame before the frame is discarded
DEF_PHASE_INC, 16'h0400, reset value of the staged and committed phase increment
DEF_AMP, 8'hFF, reset value of the staged and committed amplitude

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  received byte, valid only while rx_valid=1
rx_valid  input  1  single-cycle strobe, one received byte
tx_data  output  8  byte to transmit
tx_valid  output  1  transmit request, held until accepted
tx_ready  input  1  transmitter can accept; byte transfers when tx_valid&&tx_ready
wrap_pulse  input  1  single-cycle pulse from the sine generator when the phase accumulator wraps
phase_inc  output  16  committed phase increment to the sine generator
amp  output  8  committed amplitude scale
run  output  1  generator enable
overrun  output  1  sticky flag: an rx byte was dropped while a response was being sent

Behaviour:
- Reset (async, rst_n=0): state=IDLE, tx_valid=0, tx_data=0, phase_inc=DEF_PHASE_INC, amp=DEF_AMP, run=0, overrun=0, staged registers=defaults, pending=0, timeout counter=0.
- Frame format: 0xA5, CMD, DHI, DLO, CHK. CHK = CMD^DHI^DLO.
- FSM states: IDLE -> (rx 0xA5) CMD -> DHI -> DLO -> CHK -> EXEC -> RESP -> IDLE.
  - In IDLE, non-0xA5 bytes are ignored.
  - In CMD/DHI/DLO/CHK, each rx_valid stores the byte and advances one state.
  - The timeout counter clears on every accepted byte and increments otherwise. When it reaches TIMEOUT_CYCLES, return to IDLE silently with no response.
- EXEC (one cycle) evaluates the frame:
  - checksum mismatch or CMD not in 0x01..0x04: response = {0x15}, no state change.
  - 0x01: staged_inc = {DHI,DLO}, pending=1, response {0x06}.
  - 0x02: staged_amp = DLO, pending=1, response {0x06}.
  - 0x03: run = DLO[0], effective the cycle after EXEC, response {0x06}.
  - 0x04: response {0x06, phase_inc[15:8], phase_inc[7:0]}, using committed values sampled in EXEC.
- RESP: the response buffer holds 1..3 bytes plus a count.
  - tx_valid=1 with tx_data = current byte; advance on tx_valid&&tx_ready.
  - After the last byte is accepted: tx_valid=0, state=IDLE.
  - tx_data must be stable while tx_valid=1 and not yet accepted.
- Any rx_valid in EXEC or RESP is dropped and sets overrun=1. overrun clears only on reset.
- Commit rule:
  - If pending and run=1, copy staged_inc/staged_amp to phase_inc/amp on the cycle wrap_pulse=1, then clear pending.
  - If pending and run=0, commit on the next cycle with no wrap required.
  - If an EXEC write and a wrap_pulse occur in the same cycle, commit the old staged values and keep the new write pending for the next wrap.
  - Consecutive writes before a commit overwrite the staged value (last write wins).
- Latency: last frame byte (CHK) to tx_valid=1 is 2 cycles (CHK->EXEC->RESP).
- Timeout counter saturates at TIMEOUT_CYCLES. It is active only in CMD..CHK and is held at 0 in the other states.

Decomposition:
- Shared package sine_cfg_pkg holds:
  - header constant 0xA5, ACK 0x06, NAK 0x15
  - command codes CMD_SET_INC=0x01, CMD_SET_AMP=0x02, CMD_RUN=0x03, CMD_STATUS=0x04
  - FSM state enum
  - timeout counter width derived via $clog2(TIMEOUT_CYCLES+1)
- One natural sub-module: sine_cfg_resp_tx, holding the 3-byte response buffer, count, and the tx_valid/tx_ready handshake.
- Frame parsing and commit logic stay in the top module.

Test Plan:
- Reset then idle 10 cycles -> phase_inc=0x0400, amp=0xFF, run=0, tx_valid=0, overrun=0.
- run=0; frame A5 01 08 00 09 -> tx byte 0x06; phase_inc=0x0800 one cycle after EXEC with no wrap_pulse needed.
- Send A5 03 00 01 02 (ACK, run=1); then A5 02 00 80 82 -> ACK, amp stays 0xFF until the next wrap_pulse, then 0x80. Also drive wrap_pulse in the same cycle as EXEC and check the new value commits only on the following wrap.
- Frame A5 04 00 00 04 with phase_inc=0x0800, tx_ready toggling 1 cycle on / 3 cycles off -> bytes 0x06, 0x08, 0x00 in order; tx_data stable while stalled.
- Bad checksum A5 01 12 34 00 -> single 0x15; phase_inc unchanged. Unknown CMD A5 07 00 00 07 -> 0x15.
- Send A5 01 then silence for TIMEOUT_CYCLES+1 cycles, then A5 02 00 80 82 -> exactly one 0x06, amp=0x80 (run=0). Then inject rx_valid during RESP -> overrun=1 and the dropped byte is not parsed.

Source files
------------

// File: rtl/sine_cfg_pkg.sv
// ---------------------------------------------------------------------------
// sine_cfg_pkg: frame constants, command codes and FSM states for sine_cfg_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sine_cfg_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  localparam logic [7:0] CMD_SET_INC = 8'h01;
  localparam logic [7:0] CMD_SET_AMP = 8'h02;
  localparam logic [7:0] CMD_RUN     = 8'h03;
  localparam logic [7:0] CMD_STATUS  = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DHI  = 3'd2,
    ST_DLO  = 3'd3,
    ST_CHK  = 3'd4,
    ST_EXEC = 3'd5,
    ST_RESP = 3'd6
  } state_t;

  function automatic int tmo_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sine_cfg_resp_tx.sv
// ---------------------------------------------------------------------------
// sine_cfg_resp_tx: 1..3 byte response buffer driving the UART TX valid/ready handshake. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sine_cfg_resp_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [23:0] load_bytes,
  input  logic [1:0]  load_cnt,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        last_accept
);

  logic [7:0] sh1;
  logic [7:0] sh2;
  logic [1:0] remaining;

  // tx_data only moves on an accepted transfer, so it is stable while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      sh1       <= 8'h00;
      sh2       <= 8'h00;
      remaining <= 2'd0;
    end else if (load) begin
      tx_valid  <= 1'b1;
      tx_data   <= load_bytes[23:16];
      sh1       <= load_bytes[15:8];
      sh2       <= load_bytes[7:0];
      remaining <= load_cnt - 2'd1;
    end else if (tx_valid && tx_ready) begin
      if (remaining == 2'd0) begin
        tx_valid <= 1'b0;
      end else begin
        tx_data   <= sh1;
        sh1       <= sh2;
        remaining <= remaining - 2'd1;
      end
    end
  end

  assign last_accept = tx_valid && tx_ready && (remaining == 2'd0);

endmodule

`default_nettype wire

// File: rtl/sine_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// sine_cfg_ctrl: UART frame parser staging sine generator settings, committed on phase wrap. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sine_cfg_ctrl
  import sine_cfg_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [15:0] DEF_PHASE_INC  = 16'h0400,
  parameter logic [7:0]  DEF_AMP        = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        wrap_pulse,
  output logic [15:0] phase_inc,
  output logic [7:0]  amp,
  output logic        run,
  output logic        overrun
);

  localparam int           TW      = tmo_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  state_t        state;
  logic [7:0]    cmd, dhi, dlo, chk;
  logic [TW-1:0] tmo;
  logic [15:0]   staged_inc;
  logic [7:0]    staged_amp;
  logic          pending;

  logic          frame_ok;
  logic          resp_load;
  logic [23:0]   resp_bytes;
  logic [1:0]    resp_cnt;
  logic          last_accept;
  logic          commit;
  logic          in_frame;
  logic          tmo_expired;

  always_comb begin
    frame_ok   = ((cmd ^ dhi ^ dlo) == chk) && (cmd >= CMD_SET_INC) && (cmd <= CMD_STATUS);
    resp_bytes = {NAK_BYTE, 16'h0000};
    resp_cnt   = 2'd1;
    if (frame_ok) begin
      if (cmd == CMD_STATUS) begin
        resp_bytes = {ACK_BYTE, phase_inc};
        resp_cnt   = 2'd3;
      end else begin
        resp_bytes = {ACK_BYTE, 16'h0000};
      end
    end
  end

  assign resp_load   = (state == ST_EXEC);
  // Stopped generator has no wrap to wait for, so commit immediately
  assign commit      = pending && (!run || wrap_pulse);
  assign in_frame    = state inside {ST_CMD, ST_DHI, ST_DLO, ST_CHK};
  assign tmo_expired = (tmo == TMO_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cmd        <= 8'h00;
      dhi        <= 8'h00;
      dlo        <= 8'h00;
      chk        <= 8'h00;
      tmo        <= '0;
      staged_inc <= DEF_PHASE_INC;
      staged_amp <= DEF_AMP;
      pending    <= 1'b0;
      phase_inc  <= DEF_PHASE_INC;
      amp        <= DEF_AMP;
      run        <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Commit first so a same-cycle EXEC write re-arms pending afterwards
      if (commit) begin
        phase_inc <= staged_inc;
        amp       <= staged_amp;
        pending   <= 1'b0;
      end

      if (!in_frame || rx_valid) begin
        tmo <= '0;
      end else if (!tmo_expired) begin
        tmo <= tmo + 1'b1;
      end

      if ((state == ST_EXEC || state == ST_RESP) && rx_valid) begin
        overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: if (rx_valid && rx_data == HDR_BYTE) state <= ST_CMD;
        ST_CMD: begin
          if (rx_valid) begin
            cmd   <= rx_data;
            state <= ST_DHI;
          end else if (tmo_expired) state <= ST_IDLE;
        end
        ST_DHI: begin
          if (rx_valid) begin
            dhi   <= rx_data;
            state <= ST_DLO;
          end else if (tmo_expired) state <= ST_IDLE;
        end
        ST_DLO: begin
          if (rx_valid) begin
            dlo   <= rx_data;
            state <= ST_CHK;
          end else if (tmo_expired) state <= ST_IDLE;
        end
        ST_CHK: begin
          if (rx_valid) begin
            chk   <= rx_data;
            state <= ST_EXEC;
          end else if (tmo_expired) state <= ST_IDLE;
        end
        ST_EXEC: begin
          if (frame_ok) begin
            if (cmd == CMD_SET_INC) begin
              staged_inc <= {dhi, dlo};
              pending    <= 1'b1;
            end
            if (cmd == CMD_SET_AMP) begin
              staged_amp <= dlo;
              pending    <= 1'b1;
            end
            if (cmd == CMD_RUN) run <= dlo[0];
          end
          state <= ST_RESP;
        end
        ST_RESP: if (last_accept) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  sine_cfg_resp_tx u_resp_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (resp_load),
    .load_bytes  (resp_bytes),
    .load_cnt    (resp_cnt),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .last_accept (last_accept)
  );

endmodule

`default_nettype wire

// File: tb/tb_sine_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sine_cfg_ctrl: scoreboard bench for sine_cfg_ctrl with a command-level reference model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_sine_cfg_ctrl;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        wrap_pulse = 1'b0;
  logic [15:0] phase_inc;
  logic [7:0]  amp;
  logic        run;
  logic        overrun;

  always #5 clk = ~clk;

  sine_cfg_ctrl #(
    .TIMEOUT_CYCLES (TMO),
    .DEF_PHASE_INC  (16'h0400),
    .DEF_AMP        (8'hFF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .wrap_pulse (wrap_pulse),
    .phase_inc  (phase_inc),
    .amp        (amp),
    .run        (run),
    .overrun    (overrun)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int rdy_mode = 0;

  // Reference model: committed, staged and pending values at command level
  logic [15:0] m_inc  = 16'h0400;
  logic [15:0] m_sinc = 16'h0400;
  logic [7:0]  m_amp  = 8'hFF;
  logic [7:0]  m_samp = 8'hFF;
  logic        m_run  = 1'b0;
  logic        m_pend = 1'b0;
  logic        m_ovr  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_commit();
    m_inc  = m_sinc;
    m_amp  = m_samp;
    m_pend = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic gap(input int max_gap);
    int n;
    n = $urandom_range(0, max_gap);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 300) begin
      tick();
      n++;
    end
    check("drain_bound", 32'(n < 300), 32'd1);
    tick();
    tick();
    if (m_pend && !m_run) model_commit();
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] dh, input logic [7:0] dl,
                            input logic [7:0] ck, input bit wrap_exec, input bit drain);
    bit ok;
    ok = ((c ^ dh ^ dl) == ck) && (c >= 8'h01) && (c <= 8'h04);
    send_byte(8'hA5); gap(2);
    send_byte(c);     gap(2);
    send_byte(dh);    gap(2);
    send_byte(dl);    gap(2);
    if (!ok) exp_q.push_back(8'h15);
    else begin
      exp_q.push_back(8'h06);
      if (c == 8'h04) begin
        exp_q.push_back(m_inc[15:8]);
        exp_q.push_back(m_inc[7:0]);
      end
    end
    if (wrap_exec && m_pend) model_commit();
    if (ok) begin
      if (c == 8'h01) begin m_sinc = {dh, dl}; m_pend = 1'b1; end
      if (c == 8'h02) begin m_samp = dl; m_pend = 1'b1; end
      if (c == 8'h03) m_run = dl[0];
    end
    send_byte(ck);
    check("exec_valid_low", 32'(tx_valid), 32'd0);
    wrap_pulse = wrap_exec;
    tick();
    wrap_pulse = 1'b0;
    check("latency_valid", 32'(tx_valid), 32'd1);
    if (drain) wait_drain();
  endtask

  task automatic pulse_wrap();
    wrap_pulse = 1'b1;
    tick();
    wrap_pulse = 1'b0;
    if (m_pend) model_commit();
    tick();
  endtask

  task automatic check_state(input string tag);
    check({tag, "_phase_inc"}, 32'(phase_inc), 32'(m_inc));
    check({tag, "_amp"}, 32'(amp), 32'(m_amp));
    check({tag, "_run"}, 32'(run), 32'(m_run));
    check({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
  endtask

  // tx_ready driver: 0 always on, 1 random, 2 one-on/three-off, 3 held off
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(0, 1));
        2:       tx_ready = ((ph % 4) == 0);
        default: tx_ready = 1'b0;
      endcase
      ph++;
    end
  end

  // Monitor: pops expected bytes on each handshake and checks stall stability
  initial begin
    logic       stalled;
    logic [7:0] held;
    stalled = 1'b0;
    held    = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (tx_valid && stalled) check("tx_stable", 32'(tx_data), 32'(held));
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected actual=%0h required=none at %0t", tx_data, $time);
          end else begin
            check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
          end
          stalled = 1'b0;
        end else begin
          stalled = tx_valid;
          held    = tx_data;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] c, dh, dl, ck;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check_state("rst");

    rdy_mode = 0;
    send_frame(8'h01, 8'h08, 8'h00, 8'h09, 1'b0, 1'b1);
    check_state("set_inc_stopped");

    send_frame(8'h03, 8'h00, 8'h01, 8'h02, 1'b0, 1'b1);
    send_frame(8'h02, 8'h00, 8'h80, 8'h82, 1'b0, 1'b1);
    check_state("amp_before_wrap");
    pulse_wrap();
    check_state("amp_after_wrap");

    send_frame(8'h02, 8'h00, 8'h40, 8'h42, 1'b0, 1'b1);
    send_frame(8'h01, 8'h0C, 8'h00, 8'h0D, 1'b1, 1'b1);
    check_state("wrap_at_exec");
    pulse_wrap();
    check_state("wrap_following");

    rdy_mode = 2;
    send_frame(8'h04, 8'h00, 8'h00, 8'h04, 1'b0, 1'b1);
    rdy_mode = 0;

    send_frame(8'h01, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1);
    send_frame(8'h07, 8'h00, 8'h00, 8'h07, 1'b0, 1'b1);
    check_state("nak_frames");

    send_frame(8'h03, 8'h00, 8'h00, 8'h03, 1'b0, 1'b1);
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TMO + 3) tick();
    check("timeout_silent", 32'(tx_valid), 32'd0);
    send_frame(8'h02, 8'h00, 8'h80, 8'h82, 1'b0, 1'b1);
    check_state("after_timeout");

    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      c  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(1, 4));
      dh = 8'($urandom);
      dl = 8'($urandom);
      ck = c ^ dh ^ dl;
      if ($urandom_range(0, 7) == 0) ck = ck ^ 8'(1 << $urandom_range(0, 7));
      send_frame(c, dh, dl, ck, ($urandom_range(0, 3) == 0), 1'b1);
      if ($urandom_range(0, 2) == 0) pulse_wrap();
      check_state("random");
    end

    rdy_mode = 3;
    send_frame(8'h04, 8'h00, 8'h00, 8'h04, 1'b0, 1'b0);
    send_byte(8'hA5);
    m_ovr = 1'b1;
    check("overrun_set", 32'(overrun), 32'd1);
    rdy_mode = 0;
    wait_drain();
    send_frame(8'h04, 8'h00, 8'h00, 8'h04, 1'b0, 1'b1);
    check_state("after_overrun");

    repeat (5) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
